// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the CPU requester (c_*), the debug/loader
// requester (d_*), the shared memory port (m_*) and the owner flag.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: both requesters plus the memory behind the arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32
);
  // CPU requester
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [31:0]   c_wdata;
  logic          c_ready;
  logic [31:0]   c_rdata;
  logic          c_err;

  // Debug / program-loader requester
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_lock;
  logic          d_ready;
  logic [31:0]   d_rdata;
  logic          d_err;

  // Single-port memory
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  // Current / last owner (0=C, 1=D)
  logic          owner;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_ready, c_rdata, c_err,
    input  d_req, d_we, d_addr, d_wdata, d_lock,
    output d_ready, d_rdata, d_err,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata,
    output owner
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_ready, c_rdata, c_err,
    output d_req, d_we, d_addr, d_wdata, d_lock,
    input  d_ready, d_rdata, d_err,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata,
    input  owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port unified instruction/data memory
// between the CPU (requester C) and the debug/program-loader port (D).
// Every access runs IDLE -> ISSUE -> RESP:
//   IDLE  : arbitrate, capture the winner's we/addr/wdata and check legality
//   ISSUE : one-cycle memory strobe (suppressed for an illegal address)
//   RESP  : one-cycle ready pulse to the winner with rdata/err
// Build option: define MEM_ARB_ROUND_ROBIN_EN to make simultaneous requests
// alternate strictly between C and D. In that build the starvation counter
// does not exist and STARVE_LIMIT has no effect. The default build (macro
// undefined) uses fixed C-over-D priority with starvation relief for D.
// Reset is asynchronous and active-high; it drops any transaction in flight.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int MEM_BYTES    = 4096,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  // Legal window compared in 64 bits so any AW up to 64 works without overflow.
  localparam logic [63:0] ADDR_LIMIT = 64'(MEM_BYTES);

  // Sequencer state and the captured transaction.
  logic [1:0]    r_state;
  logic          r_owner;
  logic          r_sel;      // winner of the transaction in flight (0=C, 1=D)
  logic          r_we;
  logic          r_illegal;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;

  // Arbitration and capture path.
  logic          w_any_req;
  logic          w_grant_d;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [31:0]   w_sel_wdata;
  logic          w_sel_illegal;
  logic          w_lock_hold;

  // Output path.
  logic          w_issue;
  logic          w_resp;
  logic          w_m_en;
  logic          w_m_we;
  logic          w_c_ready;
  logic          w_d_ready;
  logic [31:0]   w_resp_rdata;

  assign w_any_req   = bus.c_req | bus.d_req;
  // d_lock only matters once D already owns the port.
  assign w_lock_hold = bus.d_lock & r_owner & bus.d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Arbitrate: lock first, then on contention hand the port to the requester that did not own it last.
  always_comb begin
    w_grant_d = 1'b0;
    if (w_lock_hold) begin
      w_grant_d = 1'b1;
    end else if (bus.c_req && bus.d_req) begin
      w_grant_d = ~r_owner;
    end else if (bus.c_req) begin
      w_grant_d = 1'b0;
    end else if (bus.d_req) begin
      w_grant_d = 1'b1;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [3:0] STARVE_MAX = 4'd15;

  // Number of grants C has taken while D was waiting; saturates so it never wraps back below the limit.
  logic [3:0] r_starve;

  // Arbitrate: lock, then starvation relief for D, then C over D.
  always_comb begin
    w_grant_d = 1'b0;
    if (w_lock_hold) begin
      w_grant_d = 1'b1;
    end else if ((r_starve >= STARVE_LIM) && bus.d_req) begin
      w_grant_d = 1'b1;
    end else if (bus.c_req) begin
      w_grant_d = 1'b0;
    end else if (bus.d_req) begin
      w_grant_d = 1'b1;
    end
  end

  // Track how long D has been passed over; any D grant restores it to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else if ((r_state == S_IDLE) && w_any_req) begin
      if (w_grant_d) begin
        r_starve <= 4'd0;
      end else if (bus.d_req && (r_starve != STARVE_MAX)) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end
`endif

  // Select the winner's request fields and decide legality before they are captured.
  always_comb begin
    w_sel_we      = bus.c_we;
    w_sel_addr    = bus.c_addr;
    w_sel_wdata   = bus.c_wdata;
    if (w_grant_d) begin
      w_sel_we    = bus.d_we;
      w_sel_addr  = bus.d_addr;
      w_sel_wdata = bus.d_wdata;
    end
    w_sel_illegal = (64'(w_sel_addr) >= ADDR_LIMIT) || (w_sel_addr[1:0] != 2'b00);
  end

  // Sequence IDLE -> ISSUE -> RESP; grant and capture only from IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_sel     <= 1'b0;
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state   <= S_ISSUE;
            r_owner   <= w_grant_d;
            r_sel     <= w_grant_d;
            r_we      <= w_sel_we;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_illegal <= w_sel_illegal;
          end
        end
        S_ISSUE: r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_issue = (r_state == S_ISSUE);
  assign w_resp  = (r_state == S_RESP);

  // Memory strobe lasts exactly the ISSUE cycle; an illegal address never reaches memory.
  // Address and data are zeroed outside the strobe so the bus is quiet when idle.
  assign w_m_en       = w_issue & ~r_illegal;
  assign w_m_we       = w_m_en & r_we;
  assign bus.m_en     = w_m_en;
  assign bus.m_we     = w_m_we;
  assign bus.m_addr   = w_m_en ? r_addr : '0;
  assign bus.m_wdata  = w_m_we ? r_wdata : 32'h0;

  // Memory data arrives the cycle after the strobe, which is RESP; writes and errors return zero.
  assign w_resp_rdata = (w_resp && !r_we && !r_illegal) ? bus.m_rdata : 32'h0;

  // Only the winner sees ready/err/rdata; the loser's outputs stay at zero.
  assign w_c_ready   = w_resp & ~r_sel;
  assign w_d_ready   = w_resp &  r_sel;
  assign bus.c_ready = w_c_ready;
  assign bus.d_ready = w_d_ready;
  assign bus.c_err   = w_c_ready & r_illegal;
  assign bus.d_err   = w_d_ready & r_illegal;
  assign bus.c_rdata = w_c_ready ? w_resp_rdata : 32'h0;
  assign bus.d_rdata = w_d_ready ? w_resp_rdata : 32'h0;
  assign bus.owner   = r_owner;

endmodule
